// File: rtl/register_file_if.sv
// Register-file access bundle: two read ports and one write port.
// The core (master) drives the indices and write data; the register file (slave) returns the read data.
interface register_file_if #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 5
);
    logic        [AddrWidth-1:0] rs1;
    logic signed [DataWidth-1:0] rs1_data_out;
    logic        [AddrWidth-1:0] rs2;
    logic signed [DataWidth-1:0] rs2_data_out;
    logic        [AddrWidth-1:0] rd;
    logic                        rd_write_enable;
    logic        [DataWidth-1:0] rd_data_in;

    modport master (
        output rs1, rs2, rd, rd_write_enable, rd_data_in,
        input  rs1_data_out, rs2_data_out
    );

    modport slave (
        input  rs1, rs2, rd, rd_write_enable, rd_data_in,
        output rs1_data_out, rs2_data_out
    );
endinterface

// File: rtl/register_file.sv
// 2**AddrWidth x DataWidth general-purpose register file with x0 hardwired to zero.
// Reads are combinational with no write bypass; writes commit on the rising edge.
module register_file #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    register_file_if.slave        rf
);
    localparam int NumRegs = 2 ** AddrWidth;

    logic [DataWidth-1:0] regs_q [NumRegs];
    logic [DataWidth-1:0] regs_d [NumRegs];

    // Next-state storage: a single enabled write to any index except x0.
    always_comb begin
        regs_d = regs_q;
        if (rf.rd_write_enable && (rf.rd != {AddrWidth{1'b0}})) begin
            regs_d[rf.rd] = rf.rd_data_in;
        end else begin
            regs_d = regs_q;
        end
    end

    // Storage update; reset wins over a coincident write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= {DataWidth{1'b0}};
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // x0 is forced at the read mux so it reads zero even before the first reset.
    assign rf.rs1_data_out = (rf.rs1 == {AddrWidth{1'b0}}) ? {DataWidth{1'b0}}
                                                            : $signed(regs_q[rf.rs1]);
    assign rf.rs2_data_out = (rf.rs2 == {AddrWidth{1'b0}}) ? {DataWidth{1'b0}}
                                                            : $signed(regs_q[rf.rs2]);
endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus randomized traffic
// compared against an array-based reference model of the register contents.
module tb_register_file;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [31:0] model [32];

    register_file_if #(.DataWidth(32), .AddrWidth(5)) rf_if ();

    register_file #(.DataWidth(32), .AddrWidth(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (rf_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, applying the architectural rules to the model.
    task automatic clock_edge();
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (rf_if.rd_write_enable && rf_if.rd != 5'd0) begin
            model[rf_if.rd] = rf_if.rd_data_in;
        end
        #1;
    endtask

    task automatic write_reg(input logic [4:0] idx, input logic [31:0] val);
        rf_if.rd = idx;
        rf_if.rd_data_in = val;
        rf_if.rd_write_enable = 1'b1;
        clock_edge();
        rf_if.rd_write_enable = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rf_if.rd_write_enable = 1'b0;
        clock_edge();
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            rf_if.rs1 = 5'(i);
            rf_if.rs2 = 5'(31 - i);
            #1;
            checks++;
            if (rf_if.rs1_data_out !== 32'sh0 || rf_if.rs2_data_out !== 32'sh0) begin
                errors++;
                $display("FAIL reset idx %0d: rs1=%h rs2=%h required 0/0", i,
                         rf_if.rs1_data_out, rf_if.rs2_data_out);
            end
        end
    endtask

    task automatic test_basic_write();
        write_reg(5'd5, 32'hDEADBEEF);
        rf_if.rs1 = 5'd5;
        rf_if.rs2 = 5'd5;
        #1;
        checks++;
        if (rf_if.rs1_data_out !== 32'hDEADBEEF || rf_if.rs2_data_out !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL basic_write x5: rs1=%h rs2=%h required deadbeef", rf_if.rs1_data_out,
                     rf_if.rs2_data_out);
        end
        for (int i = 0; i < 32; i++) begin
            if (i == 5) continue;
            rf_if.rs1 = 5'(i);
            #1;
            checks++;
            if (rf_if.rs1_data_out !== 32'sh0) begin
                errors++;
                $display("FAIL basic_write other x%0d: got %h required 0", i, rf_if.rs1_data_out);
            end
        end
    endtask

    task automatic test_x0();
        write_reg(5'd0, 32'hFFFFFFFF);
        rf_if.rs1 = 5'd0;
        rf_if.rs2 = 5'd0;
        #1;
        checks++;
        if (rf_if.rs1_data_out !== 32'sh0 || rf_if.rs2_data_out !== 32'sh0) begin
            errors++;
            $display("FAIL x0_hardwire: rs1=%h rs2=%h required 0/0", rf_if.rs1_data_out,
                     rf_if.rs2_data_out);
        end
    endtask

    task automatic test_read_during_write();
        write_reg(5'd7, 32'h11111111);
        rf_if.rs1 = 5'd7;
        rf_if.rd = 5'd7;
        rf_if.rd_data_in = 32'h22222222;
        rf_if.rd_write_enable = 1'b1;
        #1;
        checks++;
        if (rf_if.rs1_data_out !== 32'h11111111) begin
            errors++;
            $display("FAIL rdw_before: got %h required 11111111", rf_if.rs1_data_out);
        end
        clock_edge();
        rf_if.rd_write_enable = 1'b0;
        checks++;
        if (rf_if.rs1_data_out !== 32'h22222222) begin
            errors++;
            $display("FAIL rdw_after: got %h required 22222222", rf_if.rs1_data_out);
        end
    endtask

    task automatic test_enable_gating();
        for (int i = 1; i < 32; i++) write_reg(5'(i), 32'(i) * 32'h01010101);
        for (int c = 0; c < 50; c++) begin
            rf_if.rd = 5'($urandom_range(0, 31));
            rf_if.rd_data_in = $urandom;
            rf_if.rd_write_enable = 1'b0;
            clock_edge();
        end
        for (int i = 0; i < 32; i++) begin
            rf_if.rs1 = 5'(i);
            #1;
            checks++;
            if (rf_if.rs1_data_out !== model[i]) begin
                errors++;
                $display("FAIL gating hold x%0d: got %h required %h", i, rf_if.rs1_data_out,
                         model[i]);
            end
        end
        rf_if.rs1 = 5'd3;
        rf_if.rs2 = 5'd31;
        #1;
        checks++;
        if (rf_if.rs1_data_out !== 32'h03030303 || rf_if.rs2_data_out !== 32'h1F1F1F1F) begin
            errors++;
            $display("FAIL gating dual x3/x31: got %h/%h required 03030303/1f1f1f1f",
                     rf_if.rs1_data_out, rf_if.rs2_data_out);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            rf_if.rs1 = 5'($urandom_range(0, 31));
            rf_if.rs2 = ($urandom_range(0, 3) == 0) ? rf_if.rs1 : 5'($urandom_range(0, 31));
            rf_if.rd = 5'($urandom_range(0, 31));
            rf_if.rd_data_in = $urandom;
            rf_if.rd_write_enable = ($urandom_range(0, 1) == 1);
            #1;
            checks++;
            if (rf_if.rs1_data_out !== model[rf_if.rs1] ||
                rf_if.rs2_data_out !== model[rf_if.rs2]) begin
                errors++;
                $display("FAIL random cyc %0d rs1=x%0d rs2=x%0d: got %h/%h required %h/%h", c,
                         rf_if.rs1, rf_if.rs2, rf_if.rs1_data_out, rf_if.rs2_data_out,
                         model[rf_if.rs1], model[rf_if.rs2]);
            end
            clock_edge();
        end
        rf_if.rd_write_enable = 1'b0;
    endtask

    task automatic test_back_to_back();
        // Enable held across edges: each edge writes a new value, the last one sticks;
        // then a constant rd/data rewrite is idempotent.
        rf_if.rd_write_enable = 1'b1;
        rf_if.rd = 5'd12;
        rf_if.rs1 = 5'd12;
        for (int c = 0; c < 4; c++) begin
            rf_if.rd_data_in = 32'hA0000000 + 32'(c);
            clock_edge();
            checks++;
            if (rf_if.rs1_data_out !== 32'hA0000000 + 32'(c)) begin
                errors++;
                $display("FAIL b2b step %0d: got %h required %h", c, rf_if.rs1_data_out,
                         32'hA0000000 + 32'(c));
            end
        end
        clock_edge();
        clock_edge();
        rf_if.rd_write_enable = 1'b0;
        checks++;
        if (rf_if.rs1_data_out !== 32'hA0000003) begin
            errors++;
            $display("FAIL b2b idempotent: got %h required a0000003", rf_if.rs1_data_out);
        end
    endtask

    task automatic test_reset_priority();
        write_reg(5'd9, 32'hCAFEF00D);
        rst_n = 1'b0;
        rf_if.rd = 5'd9;
        rf_if.rd_data_in = 32'h12345678;
        rf_if.rd_write_enable = 1'b1;
        clock_edge();
        rst_n = 1'b1;
        rf_if.rd_write_enable = 1'b0;
        rf_if.rs1 = 5'd9;
        #1;
        checks++;
        if (rf_if.rs1_data_out !== 32'sh0) begin
            errors++;
            $display("FAIL reset_priority x9: got %h required 0", rf_if.rs1_data_out);
        end
        for (int i = 0; i < 32; i++) begin
            rf_if.rs2 = 5'(i);
            #1;
            checks++;
            if (rf_if.rs2_data_out !== 32'sh0) begin
                errors++;
                $display("FAIL reset_priority clear x%0d: got %h required 0", i,
                         rf_if.rs2_data_out);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b1;
        rf_if.rs1 = 5'd0;
        rf_if.rs2 = 5'd0;
        rf_if.rd = 5'd0;
        rf_if.rd_data_in = 32'h0;
        rf_if.rd_write_enable = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        #2;
        test_reset();
        test_basic_write();
        test_x0();
        test_read_during_write();
        test_enable_gating();
        test_random();
        test_back_to_back();
        test_reset_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 32-entry x 32-bit general-purpose register file for the rv32i core.
- Two combinational read ports (rs1, rs2) and one synchronous write port (rd).
- Register x0 is hardwired to zero.
- The core drives addresses straight from the instruction register and consumes read data in the same cycle. Write-back is committed on the clock edge after the core asserts rd_write_enable.

Parameters:
- DataWidth, 32, width of each register in bits.
- AddrWidth, 5, register index width; number of registers = 2**AddrWidth.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- rs1  input  AddrWidth  read port 1 register index.
- rs1_data_out  output  DataWidth  contents of register rs1, signed.
- rs2  input  AddrWidth  read port 2 register index.
- rs2_data_out  output  DataWidth  contents of register rs2, signed.
- rd  input  AddrWidth  write port register index.
- rd_write_enable  input  1  when high at a rising edge, rd_data_in is written to register rd.
- rd_data_in  input  DataWidth  write data.

Behaviour:
- Storage: 2**AddrWidth registers of DataWidth bits, indices 0..31.
- Reset:
  - Reset is synchronous. Rising edge with rst_n=0 clears every register to 0.
  - Reset has priority over a simultaneous write. No write occurs in a reset cycle.
  - Outputs read 0 for every index after reset.
- Read:
  - Purely combinational, zero latency.
  - rs1_data_out = reg[rs1] and rs2_data_out = reg[rs2], updated in the same cycle the address changes.
  - Both ports are fully independent. rs1 == rs2 is legal and returns identical data on both ports.
- Register x0: reads of index 0 always return 0, regardless of any write attempt.
- Write:
  - On a rising edge with rst_n=1, rd_write_enable=1 and rd != 0: reg[rd] <= rd_data_in.
  - rd_write_enable=0 leaves all registers unchanged.
  - A write to rd=0 is silently discarded.
- Read-during-write, same cycle and same index:
  - No bypass. The read port shows the old value until the edge, then the new value immediately after it.
  - The core relies on this: it asserts write-enable in one cycle, the write commits at the next edge, and the core deasserts enable afterwards.
- Enable held high across multiple edges with constant rd/rd_data_in rewrites the same value. This is harmless and idempotent.
- Reset asserted mid-operation (e.g. during a pending write) clears all state on that edge. Subsequent reads return 0.
- Hold behaviour: while no write is enabled, all contents hold indefinitely.
- Width rules:
  - No arithmetic inside the block; data is stored bit-exact.
  - Outputs are declared signed so the core's signed compares and shifts work. The bit pattern is identical to what was written.
- Synthesis: implementable as distributed RAM or flops. No X may propagate to the outputs after reset.

Test Plan:
- Reset then read: pulse rst_n=0 for one edge, sweep rs1/rs2 over 0..31 -> both outputs 0 for every index.
- Basic write/read: write 0xDEADBEEF to x5 (enable one edge), then set rs1=5, rs2=5 -> both outputs 0xDEADBEEF in the same cycle. Other indices remain 0.
- x0 hardwire: write 0xFFFFFFFF with rd=0 -> rs1=0 reads 0x00000000; rs2=0 reads 0x00000000.
- Read-during-write: rs1=7 with reg[7]=0x11111111; drive rd=7, rd_data_in=0x22222222, enable=1 -> rs1_data_out is 0x11111111 before the edge and 0x22222222 after it, with no intermediate glitch value.
- Enable gating: fill x1..x31 with their index x 0x01010101, then drive random rd/rd_data_in with enable=0 for 50 cycles -> all contents unchanged. Dual-port read of x3/x31 returns 0x03030303/0x1F1F1F1F.
- Reset priority: assert rst_n=0 and enable=1 (rd=9, data 0x12345678) on the same edge -> x9 reads 0. All previously written registers read 0.
